fetch_ctrl: RTL

- Instruction-fetch initiator on the IF side of the IF/ID pipeline register.
- Holds the architectural fetch PC and issues one read request at a time to instruction memory, which is the DPI/C++ model behind a valid/ready pair.
- Captures the returned instruction and presents {pc, inst} to the IF/ID register through a valid/ready handshake.
- Accepts redirects (branch/jump/trap target) from later stages and discards any in-flight fetch on the wrong path.

---
 rtl/fetch_ctrl_pkg.sv | 18 +
 rtl/fetch_ctrl_en_reg.sv | 28 ++
 rtl/fetch_ctrl.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/fetch_ctrl_pkg.sv
// Shared widths, reset PC, FSM encoding and constants for the fetch controller.
package fetch_ctrl_pkg;

    localparam int unsigned FETCH_PC_W   = 32;
    localparam int unsigned FETCH_INST_W = 32;

    localparam logic [FETCH_PC_W-1:0] FETCH_RESET_PC = 32'h8000_0000;

    // Write enable level used by the holding registers.
    localparam logic WE_ON = 1'b1;

    typedef enum logic [1:0] {
        FETCH_REQ  = 2'd0,
        FETCH_WAIT = 2'd1,
        FETCH_HOLD = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/fetch_ctrl_en_reg.sv
// Parameterised register with load enable and synchronous active-low reset.
module fetch_ctrl_en_reg
    import fetch_ctrl_pkg::*;
#(
    parameter int unsigned W       = 32,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_en,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_q;

    // Load on enable; reset forces the configured value.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_q <= RST_VAL;
        end else if (i_en == WE_ON) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch controller: one outstanding imem request, captured
// instruction presented to IF/ID, redirects kill wrong-path fetches.
//
// Handshake rule on every interface: a transfer happens on a rising edge
// where valid and ready are both 1; once valid is raised the payload is held
// stable until that transfer.
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter int unsigned      PC_W     = FETCH_PC_W,
    parameter int unsigned      INST_W   = FETCH_INST_W,
    parameter logic [PC_W-1:0]  RESET_PC = FETCH_RESET_PC
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [PC_W-1:0]   imem_req_addr,
    input  logic              imem_rsp_valid,
    output logic              imem_rsp_ready,
    input  logic [INST_W-1:0] imem_rsp_data,
    output logic              if_valid,
    input  logic              if_ready,
    output logic [PC_W-1:0]   if_pc,
    output logic [INST_W-1:0] if_inst,
    input  logic              redirect_valid,
    input  logic [PC_W-1:0]   redirect_pc,
    output logic [1:0]        dbg_state
);

    fetch_state_e            r_state;
    logic                    r_kill;
    logic                    r_req_valid;
    logic [PC_W-1:0]         r_req_addr;
    logic                    r_rsp_ready;
    logic                    r_if_valid;

    logic [PC_W-1:0]         w_pc;
    logic [PC_W-1:0]         w_target;
    logic [PC_W-1:0]         w_pc_next;
    logic                    w_req_fire;
    logic                    w_rsp_fire;
    logic                    w_if_fire;
    logic                    w_pc_en;
    logic                    w_if_en;
    logic [PC_W+INST_W-1:0]  w_if_d;
    logic [PC_W+INST_W-1:0]  w_if_q;

    // Redirect targets are word aligned; the low two bits are dropped.
    assign w_target   = redirect_pc & ~PC_W'(3);

    // Each valid is only ever raised in its own state, so the fires
    // need no extra state qualification.
    assign w_req_fire = r_req_valid & imem_req_ready;
    assign w_rsp_fire = r_rsp_ready & imem_rsp_valid;
    assign w_if_fire  = r_if_valid & if_ready;

    // Next fetch PC: redirect beats sequential advance, which only happens on IF delivery.
    always_comb begin
        w_pc_next = w_pc;
        if (redirect_valid) begin
            w_pc_next = w_target;
        end else if (w_if_fire) begin
            w_pc_next = w_pc + PC_W'(4);
        end
    end

    assign w_pc_en = redirect_valid | w_if_fire;

    // A response is captured only when it is on the right path.
    assign w_if_en = w_rsp_fire & ~r_kill & ~redirect_valid;
    assign w_if_d  = {w_pc, imem_rsp_data};

    fetch_ctrl_en_reg #(
        .W       (PC_W),
        .RST_VAL (RESET_PC)
    ) u_pc_reg (
        .clk  (clk),
        .rst  (rst),
        .i_en (w_pc_en),
        .i_d  (w_pc_next),
        .o_q  (w_pc)
    );

    fetch_ctrl_en_reg #(
        .W       (PC_W + INST_W),
        .RST_VAL ({RESET_PC, {INST_W{1'b0}}})
    ) u_if_reg (
        .clk  (clk),
        .rst  (rst),
        .i_en (w_if_en),
        .i_d  (w_if_d),
        .o_q  (w_if_q)
    );

    // Fetch FSM with registered handshake outputs and the wrong-path kill flag.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= FETCH_REQ;
            r_kill      <= 1'b0;
            r_req_valid <= 1'b0;
            r_req_addr  <= RESET_PC;
            r_rsp_ready <= 1'b0;
            r_if_valid  <= 1'b0;
        end else begin
            case (r_state)
                FETCH_REQ: begin
                    if (!r_req_valid) begin
                        // Only right after reset: nothing issued yet, so a
                        // redirect here simply retargets the first request.
                        r_req_valid <= 1'b1;
                        r_req_addr  <= w_pc_next;
                    end else begin
                        if (redirect_valid) begin
                            r_kill <= 1'b1;
                        end
                        if (w_req_fire) begin
                            r_req_valid <= 1'b0;
                            r_rsp_ready <= 1'b1;
                            r_state     <= FETCH_WAIT;
                        end
                    end
                end
                FETCH_WAIT: begin
                    if (w_rsp_fire) begin
                        r_rsp_ready <= 1'b0;
                        r_kill      <= 1'b0;
                        if (r_kill || redirect_valid) begin
                            // Wrong-path data: drop it and fetch from pc.
                            r_state     <= FETCH_REQ;
                            r_req_valid <= 1'b1;
                            r_req_addr  <= w_pc_next;
                        end else begin
                            r_state    <= FETCH_HOLD;
                            r_if_valid <= 1'b1;
                        end
                    end else if (redirect_valid) begin
                        r_kill <= 1'b1;
                    end
                end
                FETCH_HOLD: begin
                    if (redirect_valid || if_ready) begin
                        r_if_valid  <= 1'b0;
                        r_state     <= FETCH_REQ;
                        r_req_valid <= 1'b1;
                        r_req_addr  <= w_pc_next;
                    end
                end
                default: begin
                    r_state     <= FETCH_REQ;
                    r_kill      <= 1'b0;
                    r_req_valid <= 1'b0;
                    r_rsp_ready <= 1'b0;
                    r_if_valid  <= 1'b0;
                end
            endcase
        end
    end

    assign imem_req_valid = r_req_valid;
    assign imem_req_addr  = r_req_addr;
    assign imem_rsp_ready = r_rsp_ready;
    assign if_valid       = r_if_valid;
    assign if_pc          = w_if_q[PC_W+INST_W-1:INST_W];
    assign if_inst        = w_if_q[INST_W-1:0];
    assign dbg_state      = r_state;

endmodule
